// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the SRAM port arbiter: FSM states, access owner,
// default access length and the bus enable constants.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam int unsigned WAIT_CYCLES_DEF = 2;

  localparam logic       CHIP_ENABLE   = 1'b1;
  localparam logic       CHIP_DISABLE  = 1'b0;
  localparam logic       WRITE_ENABLE  = 1'b1;
  localparam logic       WRITE_DISABLE = 1'b0;
  localparam logic [3:0] SEL_WORD      = 4'b1111;

endpackage

// File: rtl/sram_arbiter.sv
// Time-shares one external SRAM port between instruction fetch and data access.
// One fixed-length access at a time, data wins ties, stall held until all pending ports are served.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_ce_i,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_data_o,
  output logic        inst_ack_o,
  input  logic        data_ce_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_sel_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_ack_o,
  output logic        stallreq_o,
  output logic        bus_ce_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i
);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        served_inst_q, served_inst_d;
  logic        served_data_q, served_data_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic [31:0] data_rdata_q, data_rdata_d;

  logic pend_i, pend_d;
  logic done_inst, done_data;
  logic busy;

  assign pend_i    = inst_ce_i & ~served_inst_q;
  assign pend_d    = data_ce_i & ~served_data_q;
  assign busy      = (state_q == ST_BUSY);
  assign done_inst = (state_q == ST_DONE) && (owner_q == OWN_INST);
  assign done_data = (state_q == ST_DONE) && (owner_q == OWN_DATA);

  // The port being acked is already satisfied, so it no longer holds the pipeline.
  assign stallreq_o = (pend_i & ~done_inst) | (pend_d & ~done_data);

  // Served bits stop a still-asserted request from being re-granted while the
  // pipeline is stalled; they clear on the edge where the pipeline advances.
  always_comb begin
    served_inst_d = 1'b0;
    served_data_d = 1'b0;
    if (stallreq_o) begin
      served_inst_d = served_inst_q | done_inst;
      served_data_d = served_data_q | done_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    sel_d        = sel_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    inst_data_d  = inst_data_q;
    data_rdata_d = data_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pend_d) begin
          we_d    = data_we_i ? WRITE_ENABLE : WRITE_DISABLE;
          sel_d   = data_sel_i;
          addr_d  = data_addr_i;
          wdata_d = data_wdata_i;
          cnt_d   = 4'(WAIT_CYCLES);
          owner_d = OWN_DATA;
          state_d = ST_BUSY;
        end else if (pend_i) begin
          we_d    = WRITE_DISABLE;
          sel_d   = SEL_WORD;
          addr_d  = inst_addr_i;
          wdata_d = '0;
          cnt_d   = 4'(WAIT_CYCLES);
          owner_d = OWN_INST;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd1) begin
          if (owner_q == OWN_INST) begin
            inst_data_d = bus_rdata_i;
          end else if (!we_q) begin
            data_rdata_d = bus_rdata_i;
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      owner_q       <= OWN_INST;
      cnt_q         <= '0;
      served_inst_q <= 1'b0;
      served_data_q <= 1'b0;
      we_q          <= 1'b0;
      sel_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      inst_data_q   <= '0;
      data_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      served_inst_q <= served_inst_d;
      served_data_q <= served_data_d;
      we_q          <= we_d;
      sel_q         <= sel_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      inst_data_q   <= inst_data_d;
      data_rdata_q  <= data_rdata_d;
    end
  end

  assign bus_ce_o     = busy ? CHIP_ENABLE : CHIP_DISABLE;
  assign bus_we_o     = busy & we_q;
  assign bus_sel_o    = busy ? sel_q   : 4'b0000;
  assign bus_addr_o   = busy ? addr_q  : 32'h0;
  assign bus_wdata_o  = busy ? wdata_q : 32'h0;
  assign inst_ack_o   = done_inst;
  assign data_ack_o   = done_data;
  assign inst_data_o  = inst_data_q;
  assign data_rdata_o = data_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small SRAM model and per-port
// expected-read-data queues drained on each ack.
module tb_sram_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_ce_i;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_data_o;
  logic        inst_ack_o;
  logic        data_ce_i;
  logic        data_we_i;
  logic [3:0]  data_sel_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic        data_ack_o;
  logic        stallreq_o;
  logic        bus_ce_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;

  int errors = 0;
  int checks = 0;

  logic [31:0] inst_exp_q[$];
  logic [31:0] data_exp_q[$];

  sram_arbiter #(.WAIT_CYCLES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_ce_i    (inst_ce_i),
    .inst_addr_i  (inst_addr_i),
    .inst_data_o  (inst_data_o),
    .inst_ack_o   (inst_ack_o),
    .data_ce_i    (data_ce_i),
    .data_we_i    (data_we_i),
    .data_sel_i   (data_sel_i),
    .data_addr_i  (data_addr_i),
    .data_wdata_i (data_wdata_i),
    .data_rdata_o (data_rdata_o),
    .data_ack_o   (data_ack_o),
    .stallreq_o   (stallreq_o),
    .bus_ce_o     (bus_ce_o),
    .bus_we_o     (bus_we_o),
    .bus_sel_o    (bus_sel_o),
    .bus_addr_o   (bus_addr_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_rdata_i  (bus_rdata_i)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM contents
  function automatic logic [31:0] sram_word(input logic [31:0] addr);
    case (addr)
      32'h0000_0004: return 32'h3401_0020;
      32'h0000_0008: return 32'h3C01_ABCD;
      32'h0000_0100: return 32'h1111_2222;
      default:       return addr ^ 32'hA5A5_0000;
    endcase
  endfunction

  assign bus_rdata_i = bus_ce_o ? sram_word(bus_addr_o) : 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_idle_bus(input string tag);
    check({tag, "_ce"},   32'(bus_ce_o),  32'h0);
    check({tag, "_we"},   32'(bus_we_o),  32'h0);
    check({tag, "_sel"},  32'(bus_sel_o), 32'h0);
    check({tag, "_addr"}, bus_addr_o,     32'h0);
  endtask

  // scoreboard: every ack must match the head of that port's queue
  always @(negedge clk) begin
    if (inst_ack_o) begin
      checks++;
      assert (inst_exp_q.size() > 0) else begin
        errors++;
        $error("FAIL inst_ack_unexpected: observed=1 expected=0");
      end
      if (inst_exp_q.size() > 0) check("inst_data_sb", inst_data_o, inst_exp_q.pop_front());
    end
    if (data_ack_o) begin
      checks++;
      assert (data_exp_q.size() > 0) else begin
        errors++;
        $error("FAIL data_ack_unexpected: observed=1 expected=0");
      end
      if (data_exp_q.size() > 0) check("data_rdata_sb", data_rdata_o, data_exp_q.pop_front());
    end
  end

  initial begin
    rst = 1'b1;
    inst_ce_i = 1'b1;
    inst_addr_i = 32'h4;
    data_ce_i = 1'b0;
    data_we_i = 1'b0;
    data_sel_i = 4'h0;
    data_addr_i = 32'h0;
    data_wdata_i = 32'h0;

    // 1. reset held two edges with a fetch request present
    repeat (2) @(posedge clk);
    step();
    check_idle_bus("rst_bus");
    check("rst_inst_ack",   32'(inst_ack_o), 32'h0);
    check("rst_data_ack",   32'(data_ack_o), 32'h0);
    check("rst_inst_data",  inst_data_o,     32'h0);
    check("rst_data_rdata", data_rdata_o,    32'h0);
    check("rst_wdata",      bus_wdata_o,     32'h0);

    // 2. fetch only; cycle 0 is the first cycle out of reset
    rst = 1'b0;
    inst_exp_q.push_back(32'h3401_0020);
    #1 check("f_c0_stall", 32'(stallreq_o), 32'h1);
    for (int c = 1; c <= 2; c++) begin
      step();
      check("f_bus_ce",   32'(bus_ce_o),   32'h1);
      check("f_bus_addr", bus_addr_o,      32'h4);
      check("f_bus_sel",  32'(bus_sel_o),  32'hF);
      check("f_bus_we",   32'(bus_we_o),   32'h0);
      check("f_stall",    32'(stallreq_o), 32'h1);
    end
    step();
    check("f_c3_ack",   32'(inst_ack_o), 32'h1);
    check("f_c3_stall", 32'(stallreq_o), 32'h0);
    check_idle_bus("f_c3");
    inst_ce_i = 1'b0;
    step();
    check("f_c4_ack", 32'(inst_ack_o), 32'h0);
    check_idle_bus("f_c4");

    // 3. data read and fetch together: data first, one idle cycle, then fetch
    data_ce_i = 1'b1; data_we_i = 1'b0; data_sel_i = 4'hF; data_addr_i = 32'h100;
    inst_ce_i = 1'b1; inst_addr_i = 32'h8;
    data_exp_q.push_back(32'h1111_2222);
    inst_exp_q.push_back(32'h3C01_ABCD);
    #1 check("s_c0_stall", 32'(stallreq_o), 32'h1);
    for (int c = 1; c <= 2; c++) begin
      step();
      check("s_dbus_ce",   32'(bus_ce_o), 32'h1);
      check("s_dbus_addr", bus_addr_o,    32'h100);
    end
    step();
    check("s_c3_dack",  32'(data_ack_o), 32'h1);
    check("s_c3_stall", 32'(stallreq_o), 32'h1);
    step();
    check("s_c4_ce",    32'(bus_ce_o),   32'h0);
    check("s_c4_stall", 32'(stallreq_o), 32'h1);
    for (int c = 5; c <= 6; c++) begin
      step();
      check("s_ibus_ce",   32'(bus_ce_o), 32'h1);
      check("s_ibus_addr", bus_addr_o,    32'h8);
      check("s_ibus_sel",  32'(bus_sel_o), 32'hF);
    end
    step();
    check("s_c7_iack",  32'(inst_ack_o), 32'h1);
    check("s_c7_stall", 32'(stallreq_o), 32'h0);
    data_ce_i = 1'b0; inst_ce_i = 1'b0;
    step();
    check_idle_bus("s_c8");

    // 4. byte-masked write leaves the held read word alone
    data_ce_i = 1'b1; data_we_i = 1'b1; data_sel_i = 4'b0011;
    data_addr_i = 32'h200; data_wdata_i = 32'hDEAD_BEEF;
    data_exp_q.push_back(32'h1111_2222);
    for (int c = 1; c <= 2; c++) begin
      step();
      check("w_bus_we",    32'(bus_we_o),  32'h1);
      check("w_bus_sel",   32'(bus_sel_o), 32'h3);
      check("w_bus_wdata", bus_wdata_o,    32'hDEAD_BEEF);
      check("w_bus_addr",  bus_addr_o,     32'h200);
    end
    step();
    check("w_c3_dack",  32'(data_ack_o),  32'h1);
    check("w_c3_rdata", data_rdata_o,     32'h1111_2222);
    data_ce_i = 1'b0; data_we_i = 1'b0; data_wdata_i = 32'h0;
    step();
    check_idle_bus("w_c4");

    // 5. reset arrives during cycle 1 of a fetch
    inst_ce_i = 1'b1; inst_addr_i = 32'h40;
    step();
    check("r_c1_ce", 32'(bus_ce_o), 32'h1);
    rst = 1'b1;
    step();
    check("r_c2_ce",    32'(bus_ce_o),   32'h0);
    check("r_c2_stall", 32'(stallreq_o), 32'h1);
    inst_ce_i = 1'b0;
    #1 check("r_c2_stall_drop", 32'(stallreq_o), 32'h0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      check("r_after_ce",   32'(bus_ce_o),   32'h0);
      check("r_after_iack", 32'(inst_ack_o), 32'h0);
    end

    // 6. data request withdrawn mid-access still completes, with no re-grant
    data_ce_i = 1'b1; data_we_i = 1'b0; data_sel_i = 4'hF; data_addr_i = 32'h300;
    data_exp_q.push_back(32'hA5A5_0300);
    step();
    check("fl_c1_ce", 32'(bus_ce_o), 32'h1);
    step();
    data_ce_i = 1'b0;
    #1 check("fl_c2_ce", 32'(bus_ce_o), 32'h1);
    step();
    check("fl_c3_dack", 32'(data_ack_o), 32'h1);
    for (int c = 4; c <= 7; c++) begin
      step();
      check("fl_no_regrant", 32'(bus_ce_o), 32'h0);
    end

    check("inst_q_empty", 32'(inst_exp_q.size()), 32'h0);
    check("data_q_empty", 32'(data_exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
